// File: rtl/ec_correct_sched.sv
// ec_correct_sched: round-robin front end sharing one ec_digit_correct
// pipeline between NUM_REQ requesters, with drain control and a counter.
module ec_correct_sched #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 18,
   parameter int DP_LAT     = 3,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            enable,
   input  logic                            drain_req,
   input  logic                            cnt_clr,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_Y,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_cor,
   input  logic [NUM_REQ*2-1:0]            req_sign_A,
   input  logic [NUM_REQ*2-1:0]            req_sign_B,
   output logic [DATA_WIDTH-1:0]           dp_Y,
   output logic [DATA_WIDTH-1:0]           dp_cor,
   output logic [1:0]                      dp_sign_A,
   output logic [1:0]                      dp_sign_B,
   input  logic [DATA_WIDTH-1:0]           dp_Y_ret,
   input  logic [DATA_WIDTH-1:0]           dp_cor_ret,
   input  logic [1:0]                      dp_sign_A_ret,
   input  logic [1:0]                      dp_sign_B_ret,
   output logic [NUM_REQ-1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]           rsp_Y,
   output logic [DATA_WIDTH-1:0]           rsp_cor,
   output logic [1:0]                      rsp_sign_A,
   output logic [1:0]                      rsp_sign_B,
   output logic                            busy,
   output logic                            drain_done,
   output logic [CNT_WIDTH-1:0]            corr_cnt
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [IW-1:0]         rr_q, rr_d;
   logic [IW-1:0]         win;
   logic                  found;
   logic                  hs;
   logic [DP_LAT:0]       tv_q, tv_d;
   logic [IW-1:0]         tid_q [0:DP_LAT];
   logic [IW-1:0]         tid_d [0:DP_LAT];
   logic [DATA_WIDTH-1:0] dp_Y_q, dp_Y_d;
   logic [DATA_WIDTH-1:0] dp_cor_q, dp_cor_d;
   logic [1:0]            dp_sa_q, dp_sa_d;
   logic [1:0]            dp_sb_q, dp_sb_d;
   logic                  drain_done_q, drain_done_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  corr_inc;

   // first valid requester at or after the pointer, wrapping
   always_comb begin : arb
      int idx;
      idx   = 0;
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = IW'(idx);
         end
      end
   end

   assign hs        = (state_q == RUN) && !drain_req && found;
   assign req_ready = hs ? (NUM_REQ'(1) << win) : '0;

   always_comb begin
      state_d      = state_q;
      drain_done_d = 1'b0;
      unique case (state_q)
         IDLE:    if (enable && !drain_req) state_d = RUN;
         RUN:     if (drain_req) state_d = DRAIN;
         DRAIN: begin
            if (tv_q == '0) begin
               state_d      = IDLE;
               drain_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rr_d     = rr_q;
      dp_Y_d   = dp_Y_q;
      dp_cor_d = dp_cor_q;
      dp_sa_d  = dp_sa_q;
      dp_sb_d  = dp_sb_q;
      if (hs) begin
         rr_d     = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
         dp_Y_d   = req_Y[int'(win)*DATA_WIDTH +: DATA_WIDTH];
         dp_cor_d = req_cor[int'(win)*DATA_WIDTH +: DATA_WIDTH];
         dp_sa_d  = req_sign_A[int'(win)*2 +: 2];
         dp_sb_d  = req_sign_B[int'(win)*2 +: 2];
      end
   end

   always_comb begin
      tv_d     = {tv_q[DP_LAT-1:0], hs};
      tid_d[0] = win;
      for (int k = 1; k <= DP_LAT; k++) tid_d[k] = tid_q[k-1];
   end

   assign corr_inc = tv_q[DP_LAT] && (dp_sign_A_ret == 2'd2) &&
                     (dp_sign_B_ret == 2'd2);

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) cnt_d = '0;
      else if (corr_inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         rr_q         <= '0;
         tv_q         <= '0;
         for (int k = 0; k <= DP_LAT; k++) tid_q[k] <= '0;
         dp_Y_q       <= '0;
         dp_cor_q     <= '0;
         dp_sa_q      <= '0;
         dp_sb_q      <= '0;
         drain_done_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         tv_q         <= tv_d;
         for (int k = 0; k <= DP_LAT; k++) tid_q[k] <= tid_d[k];
         dp_Y_q       <= dp_Y_d;
         dp_cor_q     <= dp_cor_d;
         dp_sa_q      <= dp_sa_d;
         dp_sb_q      <= dp_sb_d;
         drain_done_q <= drain_done_d;
         cnt_q        <= cnt_d;
      end
   end

   assign dp_Y       = dp_Y_q;
   assign dp_cor     = dp_cor_q;
   assign dp_sign_A  = dp_sa_q;
   assign dp_sign_B  = dp_sb_q;
   assign rsp_valid  = tv_q[DP_LAT] ? (NUM_REQ'(1) << tid_q[DP_LAT]) : '0;
   assign rsp_Y      = dp_Y_ret;
   assign rsp_cor    = dp_cor_ret;
   assign rsp_sign_A = dp_sign_A_ret;
   assign rsp_sign_B = dp_sign_B_ret;
   assign busy       = (state_q != IDLE) || (tv_q != '0);
   assign drain_done = drain_done_q;
   assign corr_cnt   = cnt_q;
endmodule

// File: tb/tb_ec_correct_sched.sv
// Bench for ec_correct_sched: requester models, a datapath model and a
// scoreboard of expected responses in issue order.
module tb_ec_correct_sched;
   localparam int N  = 4;
   localparam int W  = 18;
   localparam int L  = 3;
   localparam int CW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset, enable, drain_req, cnt_clr;
   logic [N-1:0]    req_valid, req_ready, rsp_valid;
   logic [N*W-1:0]  req_Y, req_cor;
   logic [N*2-1:0]  req_sign_A, req_sign_B;
   logic [W-1:0]    dp_Y, dp_cor, dp_Y_ret, dp_cor_ret, rsp_Y, rsp_cor;
   logic [1:0]      dp_sign_A, dp_sign_B, dp_sign_A_ret, dp_sign_B_ret;
   logic [1:0]      rsp_sign_A, rsp_sign_B;
   logic            busy, drain_done;
   logic [CW-1:0]   corr_cnt;

   ec_correct_sched #(
      .NUM_REQ(N), .DATA_WIDTH(W), .DP_LAT(L), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .drain_req(drain_req),
      .cnt_clr(cnt_clr), .req_valid(req_valid), .req_ready(req_ready),
      .req_Y(req_Y), .req_cor(req_cor), .req_sign_A(req_sign_A),
      .req_sign_B(req_sign_B), .dp_Y(dp_Y), .dp_cor(dp_cor),
      .dp_sign_A(dp_sign_A), .dp_sign_B(dp_sign_B), .dp_Y_ret(dp_Y_ret),
      .dp_cor_ret(dp_cor_ret), .dp_sign_A_ret(dp_sign_A_ret),
      .dp_sign_B_ret(dp_sign_B_ret), .rsp_valid(rsp_valid), .rsp_Y(rsp_Y),
      .rsp_cor(rsp_cor), .rsp_sign_A(rsp_sign_A), .rsp_sign_B(rsp_sign_B),
      .busy(busy), .drain_done(drain_done), .corr_cnt(corr_cnt)
   );

   function automatic logic [W-1:0] dpf(logic [W-1:0] c);
      return W'((int'(c) + 7348) % 78125);
   endfunction

   // datapath model: L register stages, correction applied in the first
   logic [W-1:0] py [L];
   logic [W-1:0] pc [L];
   logic [1:0]   pa [L];
   logic [1:0]   pb [L];
   always @(posedge clk) begin
      py[0] <= dp_Y;
      pc[0] <= dpf(dp_cor);
      pa[0] <= dp_sign_A;
      pb[0] <= dp_sign_B;
      for (int k = 1; k < L; k++) begin
         py[k] <= py[k-1];
         pc[k] <= pc[k-1];
         pa[k] <= pa[k-1];
         pb[k] <= pb[k-1];
      end
   end
   assign dp_Y_ret      = py[L-1];
   assign dp_cor_ret    = pc[L-1];
   assign dp_sign_A_ret = pa[L-1];
   assign dp_sign_B_ret = pb[L-1];

   typedef struct {
      int       id;
      logic [W-1:0] y;
      logic [W-1:0] c;
      logic [1:0]   a;
      logic [1:0]   b;
      int       due;
   } exp_t;

   exp_t sb[$];
   int   glog[$];
   int   gcyc[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   npop = 0;
   int   exp_cnt = 0;
   int   rem [N];
   logic [W-1:0] yv [N];
   logic [W-1:0] cv [N];
   logic [1:0]   av [N];
   logic [1:0]   bv [N];
   bit   force_corr = 0;
   bit   popped = 0;
   int   exp_sw [4] = '{2, 3, 1, 3};

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic newdata(int i);
      yv[i] = W'($urandom);
      cv[i] = W'($urandom_range(0, 78124));
      av[i] = force_corr ? 2'd2 : 2'($urandom_range(0, 3));
      bv[i] = force_corr ? 2'd2 : 2'($urandom_range(0, 3));
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]          = (rem[i] > 0);
         req_Y[i*W +: W]       = yv[i];
         req_cor[i*W +: W]     = cv[i];
         req_sign_A[i*2 +: 2]  = av[i];
         req_sign_B[i*2 +: 2]  = bv[i];
      end
   endtask

   task automatic step();
      logic [N-1:0] hs;
      exp_t e;
      bit corr;
      @(negedge clk);
      chk("corr_cnt", 32'(corr_cnt), exp_cnt);
      hs = req_valid & req_ready;
      if (hs != 0) chk("grant_onehot", $countones(hs), 1);
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            e.id = i; e.y = yv[i]; e.c = dpf(cv[i]);
            e.a = av[i]; e.b = bv[i]; e.due = cyc + L + 1;
            sb.push_back(e);
            glog.push_back(i);
            gcyc.push_back(cyc);
         end
      end
      corr = 0;
      popped = 0;
      if (rsp_valid != 0) begin
         if (sb.size() == 0) begin
            chk("rsp_spurious", 32'(rsp_valid), 0);
         end else begin
            e = sb.pop_front();
            popped = 1;
            npop++;
            chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
            chk("rsp_Y", 32'(rsp_Y), 32'(e.y));
            chk("rsp_cor", 32'(rsp_cor), 32'(e.c));
            chk("rsp_sign_A", 32'(rsp_sign_A), 32'(e.a));
            chk("rsp_sign_B", 32'(rsp_sign_B), 32'(e.b));
            chk("rsp_latency", cyc, e.due);
            corr = (e.a == 2'd2) && (e.b == 2'd2);
         end
      end
      if (sb.size() > 0 && sb[0].due < cyc) begin
         chk("rsp_missing", cyc, sb[0].due);
         void'(sb.pop_front());
      end
      if (reset || cnt_clr) exp_cnt = 0;
      else if (corr && exp_cnt < 15) exp_cnt++;
      if (reset) sb.delete();
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            rem[i]--;
            newdata(i);
         end
      end
      drive();
   endtask

   initial begin
      int ndone;
      bit prev_done;
      int gsz;
      reset = 1; enable = 0; drain_req = 0; cnt_clr = 0;
      for (int i = 0; i < N; i++) begin
         rem[i] = 0;
         newdata(i);
      end
      drive();
      @(posedge clk);
      #1;
      step();
      step();
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_drain_done", 32'(drain_done), 0);
      chk("rst_dp_Y", 32'(dp_Y), 0);
      chk("rst_dp_cor", 32'(dp_cor), 0);
      chk("rst_dp_signs", 32'({dp_sign_A, dp_sign_B}), 0);

      // single requester
      reset = 0;
      enable = 1;
      rem[1] = 1;
      yv[1] = 18'h00123; cv[1] = 18'h1D000; av[1] = 2'd2; bv[1] = 2'd2;
      drive();
      #1;
      chk("idle_no_grant", 32'(req_ready), 0);
      repeat (8) step();
      chk("single_grants", glog.size(), 1);
      chk("single_winner", glog[0], 1);
      chk("single_rsps", npop, 1);
      chk("single_corr_cnt", 32'(corr_cnt), 1);

      // fairness from pointer 0
      reset = 1;
      step();
      reset = 0;
      glog.delete(); gcyc.delete(); npop = 0;
      for (int i = 0; i < N; i++) rem[i] = 3;
      drive();
      repeat (20) step();
      chk("fair_grants", glog.size(), 12);
      for (int k = 0; k < glog.size(); k++) begin
         chk("fair_order", glog[k], k % 4);
         chk("fair_cycle", gcyc[k], gcyc[0] + k);
      end
      chk("fair_rsps", npop, 12);

      // skip and wrap
      glog.delete();
      rem[2] = 1;
      drive();
      repeat (3) step();
      rem[1] = 1; rem[3] = 2;
      drive();
      repeat (8) step();
      chk("wrap_grants", glog.size(), 4);
      for (int k = 0; k < glog.size() && k < 4; k++)
         chk("wrap_order", glog[k], exp_sw[k]);

      // drain with requester 0 still valid
      glog.delete(); npop = 0;
      rem[0] = 10;
      drive();
      repeat (3) step();
      drain_req = 1;
      enable = 0;
      #1;
      chk("drain_ready", 32'(req_ready), 0);
      chk("drain_req_valid", 32'(req_valid[0]), 1);
      step();
      drain_req = 0;
      chk("busy_in_drain", 32'(busy), 1);
      ndone = 0;
      prev_done = 0;
      for (int k = 0; k < 12; k++) begin
         chk("drain_ready0", 32'(req_ready), 0);
         if (prev_done) chk("busy_after_done", 32'(busy), 0);
         if (drain_done) ndone++;
         prev_done = drain_done;
         step();
      end
      chk("drain_done_count", ndone, 1);
      chk("drain_grants", glog.size(), 3);
      chk("drain_rsps", npop, 3);
      chk("drain_sb_empty", sb.size(), 0);
      rem[0] = 0;
      drive();

      // reset with two tags in flight
      glog.delete(); npop = 0;
      enable = 1;
      rem[2] = 2;
      drive();
      repeat (3) step();
      chk("mid_grants", glog.size(), 2);
      reset = 1;
      enable = 0;
      step();
      reset = 0;
      repeat (8) step();
      chk("mid_rsps", npop, 0);
      chk("mid_busy", 32'(busy), 0);
      chk("mid_ready", 32'(req_ready), 0);
      chk("mid_corr_cnt", 32'(corr_cnt), 0);

      // saturation, then clear against a correcting result
      force_corr = 1;
      enable = 1;
      rem[0] = 20;
      newdata(0);
      drive();
      repeat (30) step();
      chk("sat_corr_cnt", 32'(corr_cnt), 15);
      rem[3] = 1;
      newdata(3);
      drive();
      gsz = glog.size();
      step();
      chk("clr_issue", glog.size(), gsz + 1);
      repeat (3) step();
      chk("pre_clr_cnt", 32'(corr_cnt), 15);
      cnt_clr = 1;
      step();
      cnt_clr = 0;
      chk("clr_coincident", 32'(popped), 1);
      chk("clr_corr_cnt", 32'(corr_cnt), 0);
      repeat (6) step();
      chk("final_sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
